ultrasonic_trigger: RTL and testbench

Drives the ultrasonic sensor's trigger pin and conditions its echo line before the echo reaches the echo pulse-width measurement stage. The block runs a periodic measurement cycle: trigger pulse, wait for echo rise, wait for echo fall, then hold off until the next period. It synchronises the raw echo and passes it through only inside a valid measurement window. It flags missing or stuck echoes so downstream averaging is not fed garbage.

---
 rtl/ultrasonic_trigger.sv | 155 +++++++++++++++
 tb/tb_ultrasonic_trigger.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ultrasonic_trigger.sv
// Ultrasonic ranging front end: periodic trigger, echo synchroniser,
// measurement-window gating and echo timeout supervision.
module ultrasonic_trigger #(
  parameter int TRIG_CYCLES   = 500,
  parameter int PERIOD_CYCLES = 3000000,
  parameter int RISE_TIMEOUT  = 250000,
  parameter int HIGH_TIMEOUT  = 1500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       echo_in,
  output logic       trig_out,
  output logic       echo_clean,
  output logic       done,
  output logic       timeout,
  output logic       busy,
  output logic [7:0] miss_count
);

  localparam int TMAX0 = (TRIG_CYCLES > RISE_TIMEOUT) ?
                         TRIG_CYCLES : RISE_TIMEOUT;
  localparam int TMAX  = (TMAX0 > HIGH_TIMEOUT) ?
                         TMAX0 : HIGH_TIMEOUT;
  localparam int TW    = $clog2(TMAX + 1);
  localparam int PW    = $clog2(PERIOD_CYCLES + 1);

  localparam logic [TW-1:0] TRIG_LAST = TW'(TRIG_CYCLES - 1);
  localparam logic [TW-1:0] RISE_LAST = TW'(RISE_TIMEOUT - 1);
  localparam logic [TW-1:0] HIGH_LAST = TW'(HIGH_TIMEOUT - 1);
  localparam logic [PW-1:0] PER_LAST  = PW'(PERIOD_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    WAIT_FALL,
    HOLDOFF
  } state_t;

  state_t          state_q;
  logic [TW-1:0]   tmr_q;
  logic [PW-1:0]   period_q;
  logic [1:0]      sync_q;
  logic            echo_prev_q;
  logic            trig_q;
  logic            clean_q;
  logic            done_q;
  logic            to_q;
  logic [7:0]      miss_q;
  logic [7:0]      miss_d;

  logic echo_s;
  logic rise;
  logic fall;

  assign echo_s = sync_q[1];
  assign rise   = echo_s & ~echo_prev_q;
  assign fall   = ~echo_s & echo_prev_q;
  assign miss_d = (miss_q == 8'hff) ? miss_q : miss_q + 8'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q      <= 2'b00;
      echo_prev_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], echo_in};
      echo_prev_q <= echo_s;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      tmr_q    <= '0;
      period_q <= '0;
      trig_q   <= 1'b0;
      clean_q  <= 1'b0;
      done_q   <= 1'b0;
      to_q     <= 1'b0;
      miss_q   <= 8'd0;
    end else begin
      done_q   <= 1'b0;
      to_q     <= 1'b0;
      clean_q  <= 1'b0;
      tmr_q    <= tmr_q + 1'b1;
      period_q <= period_q + 1'b1;
      unique case (state_q)
        IDLE: begin
          tmr_q    <= '0;
          period_q <= '0;
          if (enable) begin
            state_q <= TRIG;
            trig_q  <= 1'b1;
          end
        end
        TRIG: begin
          if (tmr_q == TRIG_LAST) begin
            state_q <= WAIT_RISE;
            trig_q  <= 1'b0;
            tmr_q   <= '0;
          end
        end
        WAIT_RISE: begin
          // a rise on the expiry cycle still counts as a valid echo
          if (rise) begin
            state_q <= WAIT_FALL;
            clean_q <= 1'b1;
            tmr_q   <= '0;
          end else if (tmr_q == RISE_LAST) begin
            state_q <= HOLDOFF;
            to_q    <= 1'b1;
            miss_q  <= miss_d;
          end
        end
        WAIT_FALL: begin
          if (fall) begin
            state_q <= HOLDOFF;
            done_q  <= 1'b1;
          end else if (tmr_q == HIGH_LAST) begin
            state_q <= HOLDOFF;
            to_q    <= 1'b1;
            miss_q  <= miss_d;
          end else begin
            clean_q <= echo_s;
          end
        end
        HOLDOFF: begin
          if (period_q == PER_LAST) begin
            tmr_q    <= '0;
            period_q <= '0;
            if (enable) begin
              state_q <= TRIG;
              trig_q  <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          trig_q  <= 1'b0;
        end
      endcase
    end
  end

  assign trig_out   = trig_q;
  assign echo_clean = clean_q;
  assign done       = done_q;
  assign timeout    = to_q;
  assign busy       = (state_q != IDLE);
  assign miss_count = miss_q;

endmodule

// File: tb/tb_ultrasonic_trigger.sv
// Directed bench for ultrasonic_trigger with shrunken timing parameters:
// trigger 5, rise timeout 20, high timeout 30, period 100 cycles.
module tb_ultrasonic_trigger;

  localparam int TC = 5;
  localparam int RT = 20;
  localparam int HT = 30;
  localparam int PC = 100;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       echo_in;
  logic       trig_out;
  logic       echo_clean;
  logic       done;
  logic       timeout;
  logic       busy;
  logic [7:0] miss_count;

  int total;
  int bad;

  ultrasonic_trigger #(
    .TRIG_CYCLES  (TC),
    .PERIOD_CYCLES(PC),
    .RISE_TIMEOUT (RT),
    .HIGH_TIMEOUT (HT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .echo_in   (echo_in),
    .trig_out  (trig_out),
    .echo_clean(echo_clean),
    .done      (done),
    .timeout   (timeout),
    .busy      (busy),
    .miss_count(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit stuck;
    int r;
    int h;
    int cc;
    int cf;
    int dn;
    int to;
    int ek;
    int miss;
  } vec_t;

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", n, act, exp);
    end
  endtask

  task automatic wait_trig();
    int n;
    n = 0;
    while (!trig_out && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("trig_start", int'(trig_out), 1);
  endtask

  // Starts on the first negedge with trig_out high; k counts negedges
  // after the trigger falls. Returns when the next trigger is seen.
  task automatic run_period(
    input  bit stuck, input int r, input int h, input int drop_k,
    output int tc, output int per, output int cc, output int cf,
    output int dn, output int to, output int ek);
    tc = 0; per = -1; cc = 0; cf = -1; dn = 0; to = 0; ek = -1;
    echo_in = stuck;
    while (trig_out && tc < 50) begin
      tc++;
      @(negedge clk);
    end
    for (int k = 0; k < 200; k++) begin
      if (trig_out) begin
        per = tc + k;
        break;
      end
      if (echo_clean) begin
        cc++;
        if (cf < 0) cf = k;
      end
      if (done) begin
        dn++;
        ek = k;
      end
      if (timeout) begin
        to++;
        ek = k;
      end
      echo_in = stuck | (k >= r && k < r + h);
      if (k == drop_k) enable = 1'b0;
      @(negedge clk);
    end
  endtask

  vec_t tbl[9];
  int tc, per, cc, cf, dn, to, ek;

  initial begin
    total = 0;
    bad   = 0;
    //          stuck r   h  cc cf dn to ek miss
    tbl[0] = '{0, 5,  20, 20, 8, 1, 0, 28, 0};
    tbl[1] = '{0, 0,  0,  0, -1, 0, 1, 20, 1};
    tbl[2] = '{1, 0,  0,  0, -1, 0, 1, 20, 2};
    tbl[3] = '{0, 0,  25, 25, 3, 1, 0, 28, 2};
    tbl[4] = '{0, 17, 10, 10, 20, 1, 0, 30, 2};
    tbl[5] = '{0, 18, 10, 0, -1, 0, 1, 20, 3};
    tbl[6] = '{0, 5,  60, 30, 8, 0, 1, 38, 4};
    tbl[7] = '{0, 5,  30, 30, 8, 1, 0, 38, 4};
    tbl[8] = '{0, 2,  1,  1, 5, 1, 0, 6, 4};

    reset   = 1'b1;
    enable  = 1'b0;
    echo_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_trig", int'(trig_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_outs", int'({echo_clean, done, timeout}), 0);
    chk("rst_miss", int'(miss_count), 0);

    reset  = 1'b0;
    enable = 1'b1;
    wait_trig();

    for (int i = 0; i < 9; i++) begin
      run_period(tbl[i].stuck, tbl[i].r, tbl[i].h, -1,
                 tc, per, cc, cf, dn, to, ek);
      chk($sformatf("v%0d_trig", i), tc, TC);
      chk($sformatf("v%0d_period", i), per, PC);
      chk($sformatf("v%0d_clean", i), cc, tbl[i].cc);
      chk($sformatf("v%0d_delay", i), cf, tbl[i].cf);
      chk($sformatf("v%0d_done", i), dn, tbl[i].dn);
      chk($sformatf("v%0d_tmo", i), to, tbl[i].to);
      chk($sformatf("v%0d_evt", i), ek, tbl[i].ek);
      chk($sformatf("v%0d_miss", i), int'(miss_count), tbl[i].miss);
    end

    for (int i = 0; i < 250; i++)
      run_period(1'b0, 0, 0, -1, tc, per, cc, cf, dn, to, ek);
    chk("sat_254", int'(miss_count), 254);
    for (int i = 0; i < 10; i++)
      run_period(1'b0, 0, 0, -1, tc, per, cc, cf, dn, to, ek);
    chk("sat_255", int'(miss_count), 255);
    chk("sat_tmo", to, 1);

    run_period(1'b0, 5, 20, 15, tc, per, cc, cf, dn, to, ek);
    chk("drop_trig", tc, TC);
    chk("drop_clean", cc, 20);
    chk("drop_done", dn, 1);
    chk("drop_evt", ek, 28);
    chk("drop_no_retrig", per, -1);
    chk("drop_busy", int'(busy), 0);
    chk("drop_miss", int'(miss_count), 255);

    enable = 1'b1;
    wait_trig();
    repeat (3) @(negedge clk);
    chk("mid_trig", int'(trig_out), 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_trig", int'(trig_out), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_outs", int'({echo_clean, done, timeout}), 0);
    chk("arst_miss", int'(miss_count), 0);
    @(negedge clk);
    reset = 1'b0;
    wait_trig();
    run_period(1'b0, 5, 20, -1, tc, per, cc, cf, dn, to, ek);
    chk("post_trig", tc, TC);
    chk("post_period", per, PC);
    chk("post_done", dn, 1);
    chk("post_clean", cc, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
